// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM state type and PS/2 framing constants
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam int PS2_FRAME_BITS = 11;
endpackage

// File: rtl/ps2_rx_if.sv
// ps2_rx_if: PS/2 pad lines and decoded byte/strobe outputs
interface ps2_rx_if;
    logic ps2_clk;
    logic ps2_data;
    logic [7:0] scancode;
    logic flag;
    logic parity_err;
    logic frame_err;
    modport master(output ps2_clk, ps2_data, input scancode, flag, parity_err, frame_err);
    modport slave(input ps2_clk, ps2_data, output scancode, flag, parity_err, frame_err);
endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronizer, glitch filter and falling-edge detector for one PS/2 line
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic vga_clk,
    input  logic rst,
    input  logic line_in,
    output logic filt_out,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic filt_q, filt_d, fall_q, fall_d, diff;
    always_comb begin
        sync_d[0] = line_in;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        diff   = sync_q[SYNC_STAGES-1] != filt_q;
        cnt_d  = diff ? cnt_q + CW'(1) : '0;
        filt_d = filt_q;
        // the level flips only once FILTER_LEN consecutive samples disagree with it
        if (diff && cnt_d == CW'(FILTER_LEN)) begin
            filt_d = ~filt_q;
            cnt_d  = '0;
        end
        fall_d = filt_q & ~filt_d;
    end
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            sync_q <= '1;
            cnt_q  <= '0;
            filt_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            fall_q <= fall_d;
        end
    end
    assign filt_out = filt_q;
    assign fall     = fall_q;
endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver with scancode strobe; PS2_BREAK_FILTER_EN hides break sequences
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input logic vga_clk,
    input logic rst,
    ps2_rx_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    ps2_state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] dsync_q, dsync_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d, scancode_q, scancode_d;
    logic par_q, par_d, flag_q, flag_d, perr_q, perr_d, ferr_q, ferr_d;
    logic fall, filt_clk, data;
`ifdef PS2_BREAK_FILTER_EN
    logic brk_q, brk_d;
`endif
    ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .vga_clk (vga_clk),
        .rst     (rst),
        .line_in (bus.ps2_clk),
        .filt_out(filt_clk),
        .fall    (fall)
    );
    always_comb begin
        dsync_d[0] = bus.ps2_data;
        for (int i = 1; i < SYNC_STAGES; i++) dsync_d[i] = dsync_q[i-1];
        data       = dsync_q[SYNC_STAGES-1];
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        scancode_d = scancode_q;
        flag_d     = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        brk_d      = brk_q;
`endif
        tmo_d      = (fall || state_q == IDLE) ? '0 : tmo_q + TW'(1);
        if (fall) begin
            case (state_q)
                IDLE: if (!data) begin
                    state_d = DATA;
                    cnt_d   = 3'd0;
                    par_d   = 1'b0;
                end
                DATA: begin
                    shift_d = {data, shift_q[7:1]};
                    par_d   = par_q ^ data;
                    cnt_d   = cnt_q + 3'd1;
                    state_d = cnt_q == 3'd7 ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = par_q ^ data;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    ferr_d  = ~data;
                    perr_d  = data & ~par_q;
                    if (data && par_q) begin
                        scancode_d = shift_q;
`ifdef PS2_BREAK_FILTER_EN
                        flag_d = ~brk_q && shift_q != PS2_BREAK_CODE;
                        brk_d  = ~brk_q && shift_q == PS2_BREAK_CODE;
`else
                        flag_d = 1'b1;
`endif
                    end
                end
            endcase
        end else if (state_q != IDLE && tmo_d == TW'(TIMEOUT_CYCLES)) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
            tmo_d   = '0;
        end
    end
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dsync_q    <= '1;
            tmo_q      <= '0;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            scancode_q <= 8'h00;
            flag_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            brk_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dsync_q    <= dsync_d;
            tmo_q      <= tmo_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            scancode_q <= scancode_d;
            flag_q     <= flag_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
`ifdef PS2_BREAK_FILTER_EN
            brk_q      <= brk_d;
`endif
        end
    end
    assign bus.scancode   = scancode_q;
    assign bus.flag       = flag_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    logic unused_ok;
    assign unused_ok = filt_clk;
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: scoreboard bench driving PS/2 frames into ps2_rx
module tb_ps2_rx;
    import ps2_pkg::*;
    typedef struct {
        logic [2:0] kind;
        logic [7:0] code;
    } ev_t;
    logic vga_clk = 1'b0;
    logic rst = 1'b1;
    logic prev_flag = 1'b0;
    int checks = 0;
    int errors = 0;
    ev_t exp_q[$];
    ev_t mon_e;
    ps2_rx_if bus();
    ps2_rx dut (.vga_clk(vga_clk), .rst(rst), .bus(bus.slave));
    always #20 vga_clk = ~vga_clk;
    always @(negedge vga_clk) begin
        if (rst) prev_flag <= 1'b0;
        else begin
            if (bus.flag && prev_flag) begin
                checks++;
                errors++;
                $display("FAIL flag_width: flag high on two consecutive cycles, required single-cycle strobe");
            end
            if (bus.flag || bus.parity_err || bus.frame_err) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got {ferr,perr,flag}=%b scancode=%h, required no event",
                             {bus.frame_err, bus.parity_err, bus.flag}, bus.scancode);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({bus.frame_err, bus.parity_err, bus.flag} !== mon_e.kind ||
                        (mon_e.kind[0] && bus.scancode !== mon_e.code)) begin
                        errors++;
                        $display("FAIL event: got {ferr,perr,flag}=%b scancode=%h, required %b scancode=%h",
                                 {bus.frame_err, bus.parity_err, bus.flag}, bus.scancode, mon_e.kind, mon_e.code);
                    end
                end
            end
            prev_flag <= bus.flag;
        end
    end
    task automatic tick(input int n);
        repeat (n) @(negedge vga_clk);
    endtask
    task automatic push_ev(input logic [2:0] kind, input logic [7:0] code);
        ev_t e;
        e.kind = kind;
        e.code = code;
        exp_q.push_back(e);
    endtask
    task automatic send_bits(input logic [7:0] b, input logic par, input logic stop, input int nbits, input int half);
        logic [PS2_FRAME_BITS-1:0] f;
        f = {stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = f[i];
            tick(half / 2);
            bus.ps2_clk = 1'b0;
            tick(half);
            bus.ps2_clk = 1'b1;
            tick(half / 2);
        end
        bus.ps2_data = 1'b1;
        tick(2 * half);
    endtask
    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d expected events never seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask
    task automatic test_reset;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        tick(5);
        checks += 4;
        if (bus.scancode !== 8'h00) begin errors++; $display("FAIL reset_scancode: got %h, required 00", bus.scancode); end
        if (bus.flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b, required 0", bus.flag); end
        if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b, required 0", bus.parity_err); end
        if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b, required 0", bus.frame_err); end
        rst = 1'b0;
        tick(5);
    endtask
    task automatic test_basic;
        push_ev(3'b001, 8'h2B);
        send_bits(8'h2B, 1'b1, 1'b1, PS2_FRAME_BITS, 1250);
        check_drained("basic");
        checks++;
        if (bus.scancode !== 8'h2B) begin errors++; $display("FAIL basic_scancode: got %h, required 2b", bus.scancode); end
    endtask
    task automatic test_parity;
        push_ev(3'b001, 8'h15);
        send_bits(8'h15, 1'b0, 1'b1, PS2_FRAME_BITS, 200);
        push_ev(3'b010, 8'h00);
        send_bits(8'h33, 1'b0, 1'b1, PS2_FRAME_BITS, 200);
        check_drained("parity");
        checks++;
        if (bus.scancode !== 8'h15) begin errors++; $display("FAIL parity_hold: got %h, required 15", bus.scancode); end
    endtask
    task automatic test_break;
`ifndef PS2_BREAK_FILTER_EN
        push_ev(3'b001, 8'hF0);
        push_ev(3'b001, 8'h22);
`endif
        send_bits(8'hF0, 1'b1, 1'b1, PS2_FRAME_BITS, 200);
        send_bits(8'h22, 1'b1, 1'b1, PS2_FRAME_BITS, 200);
        check_drained("break");
        checks++;
        if (bus.scancode !== 8'h22) begin errors++; $display("FAIL break_scancode: got %h, required 22", bus.scancode); end
    endtask
    task automatic test_timeout;
        push_ev(3'b100, 8'h00);
        send_bits(8'h0A, 1'b1, 1'b1, 6, 200);
        tick(30000);
        check_drained("timeout_ferr");
        push_ev(3'b001, 8'h22);
        send_bits(8'h22, 1'b1, 1'b1, PS2_FRAME_BITS, 200);
        check_drained("timeout_recover");
    endtask
    task automatic test_glitch;
        tick(20);
        bus.ps2_clk = 1'b0;
        tick(3);
        bus.ps2_clk = 1'b1;
        tick(50);
        check_drained("glitch");
        push_ev(3'b100, 8'h00);
        send_bits(8'h2B, 1'b1, 1'b0, PS2_FRAME_BITS, 200);
        check_drained("bad_stop");
        checks++;
        if (bus.scancode !== 8'h22) begin errors++; $display("FAIL bad_stop_hold: got %h, required 22", bus.scancode); end
    endtask
    task automatic test_mid_reset;
        send_bits(8'h3C, 1'b1, 1'b1, 6, 200);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks += 4;
        if (bus.scancode !== 8'h00) begin errors++; $display("FAIL midrst_scancode: got %h, required 00", bus.scancode); end
        if (bus.flag !== 1'b0) begin errors++; $display("FAIL midrst_flag: got %b, required 0", bus.flag); end
        if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL midrst_perr: got %b, required 0", bus.parity_err); end
        if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL midrst_ferr: got %b, required 0", bus.frame_err); end
        tick(20);
        push_ev(3'b001, 8'h15);
        send_bits(8'h15, 1'b0, 1'b1, PS2_FRAME_BITS, 200);
        check_drained("midrst_recover");
    endtask
    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_timeout();
        test_glitch();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
